// File: rtl/pgm_sched.sv
// Packet-generation scheduler: paces PGM read-engine requests by gap, probe
// interval and packet limit, with graceful stop and one packet in flight.
module pgm_sched #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRB_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_stop,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_pkt_total,
    input  logic [PRB_W-1:0] cfg_probe_every,
    output logic             sched_req,
    output logic             sched_probe,
    input  logic             rd_gnt,
    input  logic             rd_eop,
    input  logic             in_alf,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_pkt_cnt,
    output logic [CNT_W-1:0] sent_probe_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_END,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] gap_l_q, gap_l_d;
    logic [CNT_W-1:0] total_l_q, total_l_d;
    logic [PRB_W-1:0] pe_l_q, pe_l_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] prb_cnt_q, prb_cnt_d;
    logic [PRB_W-1:0] dsp_q, dsp_d;
    logic             stop_pend_q, stop_pend_d;
    logic             req_q, req_d;
    logic             probe_q, probe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             grant;
    logic             complete;
    logic             cur_probe;
    logic [CNT_W-1:0] pkt_cnt_inc;

    always_comb begin
        grant       = (state_q == S_ISSUE) && req_q && rd_gnt;
        complete    = (grant && rd_eop) || ((state_q == S_WAIT_END) && rd_eop);
        cur_probe   = (pe_l_q != '0) && (dsp_q == pe_l_q);
        pkt_cnt_inc = pkt_cnt_q + CNT_W'(1);

        state_d     = state_q;
        gap_l_d     = gap_l_q;
        total_l_d   = total_l_q;
        pe_l_d      = pe_l_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        prb_cnt_d   = prb_cnt_q;
        dsp_d       = dsp_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_en) begin
                    gap_l_d     = cfg_gap;
                    total_l_d   = cfg_pkt_total;
                    pe_l_d      = cfg_probe_every;
                    pkt_cnt_d   = '0;
                    prb_cnt_d   = '0;
                    dsp_d       = '0;
                    stop_pend_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A grant beats a simultaneous stop: the packet must finish.
                if (grant) begin
                    state_d = S_WAIT_END;
                    if (cfg_stop) stop_pend_d = 1'b1;
                end else if (cfg_stop) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_END: begin
                if (cfg_stop) stop_pend_d = 1'b1;
            end
            S_GAP: begin
                if (cfg_stop) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q <= CNT_W'(1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!cfg_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            pkt_cnt_d = pkt_cnt_inc;
            if (cur_probe) begin
                prb_cnt_d = prb_cnt_q + CNT_W'(1);
                dsp_d     = '0;
            end else if (dsp_q != '1) begin
                dsp_d = dsp_q + PRB_W'(1);
            end
            if (stop_pend_q || cfg_stop || ((total_l_q != '0) && (pkt_cnt_inc == total_l_q))) begin
                state_d = S_DONE;
            end else if (gap_l_q != '0) begin
                state_d   = S_GAP;
                gap_cnt_d = gap_l_q;
            end else begin
                state_d = S_ISSUE;
            end
        end

        // Outputs are registered, so they are derived from the next state.
        req_d   = (state_d == S_ISSUE) && !in_alf;
        probe_d = (state_d == S_ISSUE) && (pe_l_d != '0) && (dsp_d == pe_l_d);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_END) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_l_q     <= '0;
            total_l_q   <= '0;
            pe_l_q      <= '0;
            gap_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
            prb_cnt_q   <= '0;
            dsp_q       <= '0;
            stop_pend_q <= 1'b0;
            req_q       <= 1'b0;
            probe_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_l_q     <= gap_l_d;
            total_l_q   <= total_l_d;
            pe_l_q      <= pe_l_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            prb_cnt_q   <= prb_cnt_d;
            dsp_q       <= dsp_d;
            stop_pend_q <= stop_pend_d;
            req_q       <= req_d;
            probe_q     <= probe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sched_req      = req_q;
    assign sched_probe    = probe_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sent_pkt_cnt   = pkt_cnt_q;
    assign sent_probe_cnt = prb_cnt_q;

endmodule
